// File: rtl/nirs_slot_scheduler.sv
// Time-division source-slot scheduler: laser load, settle, ADC bursts per slot,
// optional dark slot, continuous frame loop until stopped.
module nirs_slot_scheduler #(
  parameter int          NUM_SLOTS        = 32,
  parameter int          SETTLE_CYCLES    = 5000,
  parameter int          SAMPLES_PER_SLOT = 4,
  parameter bit          DARK_SLOT_EN     = 1'b1,
  parameter int          TIMEOUT_CYCLES   = 100000,
  parameter logic [15:0] FRAME_CNT_INIT   = 16'h0000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [NUM_SLOTS-1:0] i_slot_mask,
  output logic [7:0]           o_laser_code,
  output logic                 o_laser_load,
  input  logic                 i_laser_done,
  output logic                 o_adc_start,
  input  logic                 i_adc_done,
  output logic [4:0]           o_slot_idx,
  output logic                 o_dark,
  output logic                 o_frame_start,
  output logic [15:0]          o_frame_cnt,
  output logic                 o_busy,
  output logic                 o_err_timeout
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD, ST_WAIT_LOAD, ST_SETTLE, ST_SAMPLE,
    ST_WAIT_ADC, ST_NEXT, ST_OFF_LOAD, ST_OFF_WAIT
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_SLOTS-1:0] mask_reg, mask_next;
  logic [4:0]           slot_reg, slot_next;
  logic [7:0]           code_reg, code_next;
  logic [7:0]           samp_reg, samp_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [15:0]          frame_cnt_reg, frame_cnt_next;
  logic                 dark_reg, dark_next;
  logic                 first_reg, first_next;
  logic                 err_reg, err_next;
  logic [NUM_SLOTS-1:0] above_mask;

  // Enabled slots strictly above the current one, for the single-cycle NEXT search
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_above
    assign above_mask[gi] = mask_reg[gi] & (slot_reg < 5'(gi));
  end

  function automatic logic [4:0] lowest(input logic [NUM_SLOTS-1:0] v);
    lowest = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) lowest = 5'(i);
    end
  endfunction

  logic wait_expired;
  assign wait_expired = (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg     <= ST_IDLE;
      mask_reg      <= '0;
      slot_reg      <= '0;
      code_reg      <= '0;
      samp_reg      <= '0;
      cnt_reg       <= '0;
      frame_cnt_reg <= FRAME_CNT_INIT;
      dark_reg      <= 1'b0;
      first_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mask_reg      <= mask_next;
      slot_reg      <= slot_next;
      code_reg      <= code_next;
      samp_reg      <= samp_next;
      cnt_reg       <= cnt_next;
      frame_cnt_reg <= frame_cnt_next;
      dark_reg      <= dark_next;
      first_reg     <= first_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mask_next      = mask_reg;
    slot_next      = slot_reg;
    code_next      = code_reg;
    samp_next      = samp_reg;
    cnt_next       = cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    dark_next      = dark_reg;
    first_next     = first_reg;
    err_next       = err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (i_start && !i_stop && (|i_slot_mask)) begin
          mask_next  = i_slot_mask;
          err_next   = 1'b0;
          slot_next  = lowest(i_slot_mask);
          code_next  = {3'b100, lowest(i_slot_mask)};
          dark_next  = 1'b0;
          first_next = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        first_next = 1'b0;
        cnt_next   = '0;
        state_next = ST_WAIT_LOAD;
      end
      ST_WAIT_LOAD: begin
        if (i_laser_done) begin
          cnt_next   = '0;
          state_next = ST_SETTLE;
        end else if (wait_expired) begin
          err_next   = 1'b1;
          code_next  = 8'h00;
          dark_next  = 1'b0;
          state_next = ST_OFF_LOAD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_reg == CW'(SETTLE_CYCLES - 1)) begin
          samp_next  = '0;
          state_next = ST_SAMPLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_SAMPLE: begin
        samp_next  = samp_reg + 1'b1;
        cnt_next   = '0;
        state_next = ST_WAIT_ADC;
      end
      ST_WAIT_ADC: begin
        if (i_adc_done) begin
          state_next = (samp_reg < 8'(SAMPLES_PER_SLOT)) ? ST_SAMPLE : ST_NEXT;
        end else if (wait_expired) begin
          err_next   = 1'b1;
          code_next  = 8'h00;
          dark_next  = 1'b0;
          state_next = ST_OFF_LOAD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_NEXT: begin
        state_next = ST_LOAD;
        if (!dark_reg && (|above_mask)) begin
          slot_next = lowest(above_mask);
          code_next = {3'b100, lowest(above_mask)};
        end else if (!dark_reg && DARK_SLOT_EN) begin
          slot_next = 5'(NUM_SLOTS - 1);
          code_next = 8'h00;
          dark_next = 1'b1;
        end else begin
          frame_cnt_next = frame_cnt_reg + 16'd1;
          slot_next      = lowest(mask_reg);
          code_next      = {3'b100, lowest(mask_reg)};
          dark_next      = 1'b0;
          first_next     = 1'b1;
        end
      end
      ST_OFF_LOAD: begin
        cnt_next   = '0;
        state_next = ST_OFF_WAIT;
      end
      ST_OFF_WAIT: begin
        if (i_laser_done) begin
          state_next = ST_IDLE;
        end else if (wait_expired) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Stop overrides everything except idle/off; any frame-complete increment is discarded
    if (i_stop && state_reg != ST_IDLE && state_reg != ST_OFF_LOAD && state_reg != ST_OFF_WAIT) begin
      state_next     = ST_OFF_LOAD;
      code_next      = 8'h00;
      dark_next      = 1'b0;
      first_next     = 1'b0;
      frame_cnt_next = frame_cnt_reg;
    end
  end

  assign o_laser_code  = code_reg;
  assign o_laser_load  = (state_reg == ST_LOAD) || (state_reg == ST_OFF_LOAD);
  assign o_adc_start   = (state_reg == ST_SAMPLE);
  assign o_slot_idx    = slot_reg;
  assign o_dark        = dark_reg;
  assign o_frame_start = (state_reg == ST_LOAD) && first_reg;
  assign o_frame_cnt   = frame_cnt_reg;
  assign o_busy        = (state_reg != ST_IDLE);
  assign o_err_timeout = err_reg;

endmodule
